// File: rtl/hwpf_pkg.sv
// Shared types for the hardware-prefetch arbiter: the HPDcache request
// struct, line-address and prefetcher-id types, and line extraction.
package hwpf_pkg;

  localparam int unsigned HWPF_ADDR_W    = 32;
  localparam int unsigned HWPF_LANE_SIZE = 64;
  localparam int unsigned HWPF_OFF_W     = $clog2(HWPF_LANE_SIZE);

  typedef logic [HWPF_ADDR_W-1:0]            addr_t;
  typedef logic [HWPF_ADDR_W-HWPF_OFF_W-1:0] hwpf_line_t;
  typedef logic [2:0]                        hwpf_id_t;

  typedef struct packed {
    addr_t       addr;
    logic [3:0]  op;
    logic [2:0]  size;
    logic [2:0]  sid;
    logic [7:0]  tid;
    logic        need_rsp;
    logic        uncacheable;
  } hpdcache_req_t;

  // Line address, right-aligned; callers truncate to their line width.
  function automatic addr_t line_of(addr_t addr, int unsigned off_w);
    return addr >> off_w;
  endfunction

endpackage

// File: rtl/hwpf_arbiter_rr.sv
// Combinational round-robin pick: first requester after last_grant_i,
// wrapping modulo N. Grants only when advance_i is high.
module hwpf_arbiter_rr #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  gnt_onehot_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    cand         = 0;
    found        = 1'b0;
    gnt_idx_o    = '0;
    gnt_onehot_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(last_grant_i) + 32'd1 + i) % N;
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = IW'(cand);
      end
    end
    gnt_valid_o = advance_i & found;
    if (gnt_valid_o) gnt_onehot_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/hwpf_arbiter.sv
// Merges NUM_HWPF prefetcher request streams into one HPDcache port with a
// recently-issued line filter and a one-entry registered output stage.
module hwpf_arbiter
  import hwpf_pkg::*;
#(
  parameter int unsigned NUM_HWPF     = 2,
  parameter int unsigned FILTER_DEPTH = 8,
  parameter int unsigned LANE_SIZE    = 64,
  parameter int unsigned SID          = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               lock_i,
  input  logic          [NUM_HWPF-1:0]       hwpf_req_valid_i,
  output logic          [NUM_HWPF-1:0]       hwpf_req_ready_o,
  input  hpdcache_req_t [NUM_HWPF-1:0]       hwpf_req_i,
  output logic                               dcache_req_valid_o,
  input  logic                               dcache_req_ready_i,
  output hpdcache_req_t                      dcache_req_o,
  output logic          [15:0]               drop_cnt_o
);

  localparam int unsigned IW     = (NUM_HWPF > 1) ? $clog2(NUM_HWPF) : 1;
  localparam int unsigned PW     = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam int unsigned OFF_W  = $clog2(LANE_SIZE);
  localparam int unsigned LINE_W = HWPF_ADDR_W - OFF_W;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_HWPF - 1);

  typedef logic [LINE_W-1:0] line_t;

  line_t             filt_q [FILTER_DEPTH];
  logic [FILTER_DEPTH-1:0] filt_v_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]     last_q;
  logic              out_v_q;
  hpdcache_req_t     out_q;
  logic [15:0]       drop_q;

  logic              stage_free, advance;
  logic [NUM_HWPF-1:0] gnt_onehot;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_valid;
  hpdcache_req_t     sel_req, issue_req;
  line_t             sel_line, out_line;
  logic              filt_hit, out_hit, hit, load, drop;

  assign stage_free = !out_v_q || dcache_req_ready_i;
  assign advance    = !lock_i && !flush_i && stage_free;

  hwpf_arbiter_rr #(
    .N  (NUM_HWPF),
    .IW (IW)
  ) i_rr (
    .req_i        (hwpf_req_valid_i),
    .advance_i    (advance),
    .last_grant_i (last_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  assign sel_req  = hwpf_req_i[gnt_idx];
  assign sel_line = line_t'(line_of(sel_req.addr, OFF_W));
  assign out_line = line_t'(line_of(out_q.addr, OFF_W));

  always_comb begin
    filt_hit = 1'b0;
    for (int unsigned k = 0; k < FILTER_DEPTH; k++) begin
      if (filt_v_q[k] && (filt_q[k] == sel_line)) filt_hit = 1'b1;
    end
  end

  // The output register covers the line accepted last cycle, whose filter
  // entry was written at the same edge and is therefore also visible now.
  assign out_hit = out_v_q && (out_line == sel_line);
  assign hit     = filt_hit || out_hit;
  assign load    = gnt_valid && !hit;
  assign drop    = gnt_valid && hit;

  assign wr_ptr_d = (32'(wr_ptr_q) == FILTER_DEPTH - 1) ? '0 : wr_ptr_q + PW'(1);

  always_comb begin
    issue_req             = sel_req;
    issue_req.sid         = 3'(SID);
    issue_req.tid         = 8'(gnt_idx);
    issue_req.need_rsp    = 1'b0;
    issue_req.uncacheable = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_v_q <= '0;
      wr_ptr_q <= '0;
      last_q   <= LAST_RST;
      for (int unsigned k = 0; k < FILTER_DEPTH; k++) filt_q[k] <= '0;
    end else if (flush_i) begin
      filt_v_q <= '0;
      wr_ptr_q <= '0;
      last_q   <= LAST_RST;
    end else if (gnt_valid) begin
      last_q <= gnt_idx;
      if (!hit) begin
        filt_q[wr_ptr_q]   <= sel_line;
        filt_v_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q           <= wr_ptr_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_v_q <= 1'b0;
      out_q   <= '0;
    end else if (load) begin
      out_v_q <= 1'b1;
      out_q   <= issue_req;
    end else if (dcache_req_ready_i) begin
      out_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign hwpf_req_ready_o   = gnt_onehot;
  assign dcache_req_valid_o = out_v_q;
  assign dcache_req_o       = out_q;
  assign drop_cnt_o         = drop_q;

endmodule

// File: tb/tb_hwpf_arbiter.sv
// Directed bench for hwpf_arbiter: hand-computed grants, drops and issued
// addresses, with a scoreboard of expected issued addresses.
module tb_hwpf_arbiter;
  import hwpf_pkg::*;

  logic                         clk_i = 1'b0;
  logic                         rst_ni = 1'b0;
  logic                         flush_i = 1'b0;
  logic                         lock_i = 1'b0;
  logic          [1:0]          hwpf_req_valid_i = '0;
  logic          [1:0]          hwpf_req_ready_o;
  hpdcache_req_t [1:0]          hwpf_req_i = '0;
  logic                         dcache_req_valid_o;
  logic                         dcache_req_ready_i = 1'b1;
  hpdcache_req_t                dcache_req_o;
  logic          [15:0]         drop_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  hwpf_arbiter #(
    .NUM_HWPF     (2),
    .FILTER_DEPTH (8),
    .LANE_SIZE    (64),
    .SID          (0)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .lock_i             (lock_i),
    .hwpf_req_valid_i   (hwpf_req_valid_i),
    .hwpf_req_ready_o   (hwpf_req_ready_o),
    .hwpf_req_i         (hwpf_req_i),
    .dcache_req_valid_o (dcache_req_valid_o),
    .dcache_req_ready_i (dcache_req_ready_i),
    .dcache_req_o       (dcache_req_o),
    .drop_cnt_o         (drop_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic drive(input logic v0, input addr_t a0, input logic v1, input addr_t a1);
    hpdcache_req_t r;
    r.op = 4'h1; r.size = 3'd3; r.sid = 3'h5; r.tid = 8'hAA;
    r.need_rsp = 1'b1; r.uncacheable = 1'b1;
    r.addr = a0; hwpf_req_i[0] = r;
    r.addr = a1; hwpf_req_i[1] = r;
    hwpf_req_valid_i = {v1, v0};
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1'b1;
    mid();
    check("flush_ready", {62'd0, hwpf_req_ready_o}, 64'd0);
    step();
    flush_i = 1'b0;
  endtask

  // scoreboard: every completed handshake must match the next expected address
  always @(negedge clk_i) begin
    if (rst_ni && dcache_req_valid_o && dcache_req_ready_i) begin
      check("sb_pending", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) check("sb_addr", {32'd0, dcache_req_o.addr}, {32'd0, exp_q.pop_front()});
    end
  end

  initial begin
    idle();
    #12;
    check("rst_valid", {63'd0, dcache_req_valid_o}, 64'd0);
    check("rst_req",   {12'd0, dcache_req_o}, 64'd0);
    check("rst_ready", {62'd0, hwpf_req_ready_o}, 64'd0);
    check("rst_drop",  {48'd0, drop_cnt_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // single request, 1-cycle latency, field overrides
    drive(1'b1, 32'h1000, 1'b0, '0);
    exp_q.push_back(32'h1000);
    mid();
    check("t1_ready", {62'd0, hwpf_req_ready_o}, 64'd1);
    step();
    idle();
    mid();
    check("t1_valid", {63'd0, dcache_req_valid_o}, 64'd1);
    check("t1_addr",  {32'd0, dcache_req_o.addr}, 64'h1000);
    check("t1_tid",   {56'd0, dcache_req_o.tid}, 64'd0);
    check("t1_sid",   {61'd0, dcache_req_o.sid}, 64'd0);
    check("t1_rsp",   {62'd0, dcache_req_o.need_rsp, dcache_req_o.uncacheable}, 64'd0);
    check("t1_op",    {60'd0, dcache_req_o.op}, 64'h1);
    step();

    // alternating grants after flush resets the pointer
    do_flush();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(i) * 32'h100, 1'b1, 32'h4000 + 32'(i) * 32'h100);
      exp_q.push_back((i % 2 == 0) ? 32'h3000 + 32'(i) * 32'h100 : 32'h4000 + 32'(i) * 32'h100);
      mid();
      check("t2_grant", {62'd0, hwpf_req_ready_o}, (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i > 0) check("t2_tid", {56'd0, dcache_req_o.tid}, (i % 2 == 1) ? 64'd0 : 64'd1);
      step();
    end
    idle();
    mid();
    check("t2_tid_last", {56'd0, dcache_req_o.tid}, 64'd1);
    check("t2_drop", {48'd0, drop_cnt_o}, 64'd0);
    step();
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // same-line repeat is dropped
    do_flush();
    drive(1'b1, 32'h2000, 1'b0, '0);
    exp_q.push_back(32'h2000);
    mid();
    check("t3_ready0", {62'd0, hwpf_req_ready_o}, 64'd1);
    step();
    drive(1'b1, 32'h2020, 1'b0, '0);
    mid();
    check("t3_ready1", {62'd0, hwpf_req_ready_o}, 64'd1);
    step();
    idle();
    mid();
    check("t3_drop",  {48'd0, drop_cnt_o}, 64'd1);
    check("t3_valid", {63'd0, dcache_req_valid_o}, 64'd0);
    step();

    // back-pressure: output stable, no accepts; release accepts same cycle
    do_flush();
    drive(1'b1, 32'h5000, 1'b0, '0);
    exp_q.push_back(32'h5000);
    step();
    dcache_req_ready_i = 1'b0;
    drive(1'b1, 32'h6000, 1'b1, 32'h6800);
    for (int i = 0; i < 5; i++) begin
      mid();
      check("t4_stall_ready", {62'd0, hwpf_req_ready_o}, 64'd0);
      check("t4_stall_addr",  {32'd0, dcache_req_o.addr}, 64'h5000);
      step();
    end
    dcache_req_ready_i = 1'b1;
    drive(1'b1, 32'h6000, 1'b0, '0);
    exp_q.push_back(32'h6000);
    mid();
    check("t4_release_ready", {62'd0, hwpf_req_ready_o}, 64'd2 - 64'd1);
    step();
    idle();
    mid();
    check("t4_next_addr", {32'd0, dcache_req_o.addr}, 64'h6000);
    step();

    // filter eviction: 9 distinct lines, line 0 evicted, then re-issued, then dropped
    do_flush();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h10000 + 32'(i) * 32'h40, 1'b0, '0);
      exp_q.push_back(32'h10000 + 32'(i) * 32'h40);
      mid();
      check("t5_fill_ready", {62'd0, hwpf_req_ready_o}, 64'd1);
      step();
    end
    drive(1'b1, 32'h10000, 1'b0, '0);
    exp_q.push_back(32'h10000);
    step();
    drive(1'b1, 32'h10008, 1'b0, '0);
    step();
    idle();
    mid();
    check("t5_drop", {48'd0, drop_cnt_o}, 64'd2);
    step();
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // lock with pending output, then flush and repeat a line
    do_flush();
    dcache_req_ready_i = 1'b0;
    drive(1'b1, 32'h7000, 1'b0, '0);
    exp_q.push_back(32'h7000);
    step();
    lock_i = 1'b1;
    drive(1'b1, 32'h8000, 1'b0, '0);
    mid();
    check("t6_lock_ready", {62'd0, hwpf_req_ready_o}, 64'd0);
    check("t6_lock_valid", {63'd0, dcache_req_valid_o}, 64'd1);
    step();
    dcache_req_ready_i = 1'b1;
    mid();
    check("t6_lock_ready2", {62'd0, hwpf_req_ready_o}, 64'd0);
    step();
    mid();
    check("t6_drained", {63'd0, dcache_req_valid_o}, 64'd0);
    check("t6_lock_ready3", {62'd0, hwpf_req_ready_o}, 64'd0);
    step();
    lock_i = 1'b0;
    do_flush();
    drive(1'b1, 32'h7000, 1'b0, '0);
    exp_q.push_back(32'h7000);
    mid();
    check("t6_reissue_ready", {62'd0, hwpf_req_ready_o}, 64'd1);
    step();
    idle();
    mid();
    check("t6_reissue_addr", {32'd0, dcache_req_o.addr}, 64'h7000);
    check("t6_drop", {48'd0, drop_cnt_o}, 64'd2);
    step();

    // same line on both inputs in one cycle
    do_flush();
    drive(1'b1, 32'h9000, 1'b1, 32'h9010);
    exp_q.push_back(32'h9000);
    mid();
    check("t7_grant0", {62'd0, hwpf_req_ready_o}, 64'd1);
    step();
    drive(1'b0, '0, 1'b1, 32'h9010);
    mid();
    check("t7_grant1", {62'd0, hwpf_req_ready_o}, 64'd2);
    step();
    idle();
    mid();
    check("t7_drop", {48'd0, drop_cnt_o}, 64'd3);
    step();
    check("t7_sb_empty", 64'(exp_q.size()), 64'd0);

    // asynchronous reset discards a stalled request
    dcache_req_ready_i = 1'b0;
    drive(1'b1, 32'hA000, 1'b0, '0);
    step();
    idle();
    mid();
    check("t8_pending", {63'd0, dcache_req_valid_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t8_rst_valid", {63'd0, dcache_req_valid_o}, 64'd0);
    check("t8_rst_drop",  {48'd0, drop_cnt_o}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
